// File: rtl/fpnew_opgroup_reorder_block.sv
`default_nettype none
// ============================================================================
// Module   : fpnew_opgroup_reorder_block
// Brief    : Reorder buffer that dispatches ops to NumChannels slices of
//            differing latency and retires their results in issue order.
// Revision : 1.0 - initial release
// ============================================================================
module fpnew_opgroup_reorder_block #(
    parameter int unsigned NumChannels = 4,
    parameter int unsigned Width       = 64,
    parameter int unsigned Depth       = 8,
    parameter int unsigned TagWidth    = 8,
    localparam int unsigned IdWidth    = $clog2(Depth) + 1,
    localparam int unsigned c_chan_w   = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [c_chan_w-1:0]          in_chan_i,
    input  logic [TagWidth-1:0]          in_tag_i,
    output logic [NumChannels-1:0]       chan_valid_o,
    input  logic [NumChannels-1:0]       chan_ready_i,
    output logic [IdWidth-1:0]           chan_id_o,
    input  logic [NumChannels-1:0]       res_valid_i,
    output logic [NumChannels-1:0]       res_ready_o,
    input  logic [NumChannels*IdWidth-1:0] res_id_i,
    input  logic [NumChannels*Width-1:0] res_data_i,
    input  logic [NumChannels*5-1:0]     res_status_i,
    input  logic [NumChannels-1:0]       res_ext_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [Width-1:0]             result_o,
    output logic [4:0]                   status_o,
    output logic                         extension_bit_o,
    output logic [TagWidth-1:0]          tag_o,
    output logic [4:0]                   fflags_o,
    input  logic                         clear_fflags_i,
    output logic                         wb_err_o,
    output logic                         busy_o
);

    localparam int unsigned       c_idx_w = $clog2(Depth);
    localparam int unsigned       c_cnt_w = c_idx_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth = Depth[c_cnt_w-1:0];

    localparam logic [1:0] c_free    = 2'd0;
    localparam logic [1:0] c_pending = 2'd1;
    localparam logic [1:0] c_done    = 2'd2;

    logic [1:0]          r_state  [Depth];
    logic [TagWidth-1:0] r_tag    [Depth];
    logic [Width-1:0]    r_data   [Depth];
    logic [4:0]          r_status [Depth];
    logic                r_ext    [Depth];

    logic [c_idx_w-1:0]  r_head;
    logic [c_idx_w-1:0]  r_tail;
    logic [c_cnt_w-1:0]  r_count;
    logic                r_epoch;
    logic [4:0]          r_fflags;
    logic                r_wb_err;

    logic                w_retire;
    logic                w_full;
    logic                w_room;
    logic                w_chan_rdy;
    logic                w_alloc;
    logic [NumChannels-1:0] w_wb_live;
    logic [NumChannels-1:0] w_wb_acc;
    logic [c_idx_w-1:0]  w_wb_idx [NumChannels];
    logic                w_wb_err;

    // Retire side
    assign out_valid_o     = (r_state[r_head] == c_done);
    assign w_retire        = out_valid_o & out_ready_i;
    assign result_o        = r_data[r_head];
    assign status_o        = r_status[r_head];
    assign extension_bit_o = r_ext[r_head];
    assign tag_o           = r_tag[r_head];
    assign fflags_o        = r_fflags;
    assign wb_err_o        = r_wb_err;
    assign busy_o          = (r_count != '0);
    assign res_ready_o     = '1;

    // A slot freed by a retire this cycle can be re-issued immediately, so a
    // full buffer still accepts when the head is leaving.
    assign w_full    = (r_count == c_depth);
    assign w_room    = ~w_full | w_retire;
    assign chan_id_o = {r_epoch, r_tail};

    always_comb begin
        w_chan_rdy = 1'b0;
        for (int c = 0; c < NumChannels; c++) begin
            if (in_chan_i == c_chan_w'(c)) begin
                w_chan_rdy = chan_ready_i[c];
            end
        end
    end

    assign in_ready_o = ~rst_i & w_room & w_chan_rdy;
    assign w_alloc    = in_valid_i & in_ready_o;

    for (genvar c = 0; c < NumChannels; c++) begin : g_chan
        assign chan_valid_o[c] = in_valid_i & ~rst_i & w_room & (in_chan_i == c_chan_w'(c));
        assign w_wb_idx[c]     = res_id_i[c*IdWidth +: c_idx_w];
        assign w_wb_live[c]    = res_valid_i[c] & (res_id_i[c*IdWidth + c_idx_w] == r_epoch);
    end

    // Stale-epoch write-backs never reach this decode; a live one that hits a
    // non-pending slot, or loses a same-slot race to a lower channel, is an error.
    always_comb begin
        w_wb_acc = '0;
        w_wb_err = 1'b0;
        for (int c = 0; c < NumChannels; c++) begin
            if (w_wb_live[c]) begin
                if (r_state[w_wb_idx[c]] == c_pending) begin
                    w_wb_acc[c] = 1'b1;
                end else begin
                    w_wb_err = 1'b1;
                end
                for (int k = 0; k < c; k++) begin
                    if (w_wb_live[k] && (w_wb_idx[k] == w_wb_idx[c])) begin
                        w_wb_acc[c] = 1'b0;
                        w_wb_err    = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < Depth; i++) begin
                r_state[i] <= c_free;
            end
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_epoch  <= 1'b0;
            r_wb_err <= 1'b0;
        end else if (flush_i) begin
            for (int i = 0; i < Depth; i++) begin
                r_state[i] <= c_free;
            end
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_epoch  <= ~r_epoch;
            r_wb_err <= 1'b0;
        end else begin
            // Alloc is applied last: when full, the slot it writes is the one retiring.
            if (w_retire) begin
                r_state[r_head] <= c_free;
            end
            for (int c = 0; c < NumChannels; c++) begin
                if (w_wb_acc[c]) begin
                    r_state[w_wb_idx[c]] <= c_done;
                end
            end
            if (w_alloc) begin
                r_state[r_tail] <= c_pending;
            end
            r_head   <= r_head + c_idx_w'(w_retire);
            r_tail   <= r_tail + c_idx_w'(w_alloc);
            r_count  <= r_count + c_cnt_w'(w_alloc) - c_cnt_w'(w_retire);
            r_wb_err <= w_wb_err;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_alloc) begin
            r_tag[r_tail] <= in_tag_i;
        end
        for (int c = 0; c < NumChannels; c++) begin
            if (w_wb_acc[c]) begin
                r_data[w_wb_idx[c]]   <= res_data_i[c*Width +: Width];
                r_status[w_wb_idx[c]] <= res_status_i[c*5 +: 5];
                r_ext[w_wb_idx[c]]    <= res_ext_i[c];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fflags <= '0;
        end else if (clear_fflags_i) begin
            r_fflags <= w_retire ? r_status[r_head] : 5'd0;
        end else if (w_retire) begin
            r_fflags <= r_fflags | r_status[r_head];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fpnew_opgroup_reorder_block.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpnew_opgroup_reorder_block
// Brief    : Directed self-checking bench for the reorder block.
// Revision : 1.0 - initial release
// ============================================================================
`define CHK(NAME, OBS, EXP) \
    begin \
        n_checks++; \
        assert ((OBS) === (EXP)) else begin \
            n_fail++; \
            $error("FAIL %s: observed 0x%0h expected 0x%0h", NAME, OBS, EXP); \
        end \
    end

module tb_fpnew_opgroup_reorder_block;

    localparam int NCH = 4;
    localparam int W   = 64;
    localparam int D   = 8;
    localparam int TW  = 8;
    localparam int IDW = 4;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             flush_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [1:0]       in_chan_i;
    logic [TW-1:0]    in_tag_i;
    logic [NCH-1:0]   chan_valid_o;
    logic [NCH-1:0]   chan_ready_i;
    logic [IDW-1:0]   chan_id_o;
    logic [NCH-1:0]   res_valid_i;
    logic [NCH-1:0]   res_ready_o;
    logic [NCH*IDW-1:0] res_id_i;
    logic [NCH*W-1:0] res_data_i;
    logic [NCH*5-1:0] res_status_i;
    logic [NCH-1:0]   res_ext_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [W-1:0]     result_o;
    logic [4:0]       status_o;
    logic             extension_bit_o;
    logic [TW-1:0]    tag_o;
    logic [4:0]       fflags_o;
    logic             clear_fflags_i;
    logic             wb_err_o;
    logic             busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    fpnew_opgroup_reorder_block #(
        .NumChannels(NCH), .Width(W), .Depth(D), .TagWidth(TW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_chan_i(in_chan_i),
        .in_tag_i(in_tag_i), .chan_valid_o(chan_valid_o), .chan_ready_i(chan_ready_i),
        .chan_id_o(chan_id_o), .res_valid_i(res_valid_i), .res_ready_o(res_ready_o),
        .res_id_i(res_id_i), .res_data_i(res_data_i), .res_status_i(res_status_i),
        .res_ext_i(res_ext_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .result_o(result_o), .status_o(status_o), .extension_bit_o(extension_bit_o),
        .tag_o(tag_o), .fflags_o(fflags_o), .clear_fflags_i(clear_fflags_i),
        .wb_err_o(wb_err_o), .busy_o(busy_o)
    );

    always @(posedge clk_i) begin
        if (rst_i === 1'b0) begin
            n_checks++;
            if ((chan_valid_o & (chan_valid_o - 1'b1)) !== '0) begin
                n_fail++;
                $error("FAIL mon_onehot: chan_valid_o 0x%0h not one-hot", chan_valid_o);
            end
            n_checks++;
            if (res_ready_o !== {NCH{1'b1}}) begin
                n_fail++;
                $error("FAIL mon_res_ready: res_ready_o 0x%0h", res_ready_o);
            end
        end
    end

    task automatic step();
        @(negedge clk_i);
    endtask

    task automatic issue(input logic [1:0] ch, input logic [7:0] tag,
                         input logic [3:0] exp_id, input string name);
        in_valid_i = 1'b1;
        in_chan_i  = ch;
        in_tag_i   = tag;
        #1;
        `CHK({name, "_ready"}, in_ready_o, 1'b1)
        `CHK({name, "_id"}, chan_id_o, exp_id)
        `CHK({name, "_chan_valid"}, chan_valid_o, 4'b0001 << ch)
        step();
        in_valid_i = 1'b0;
    endtask

    task automatic wb(input int ch, input logic [3:0] id, input logic [63:0] data,
                      input logic [4:0] st);
        res_valid_i              = '0;
        res_valid_i[ch]          = 1'b1;
        res_id_i[ch*IDW +: IDW]  = id;
        res_data_i[ch*W +: W]    = data;
        res_status_i[ch*5 +: 5]  = st;
        res_ext_i[ch]            = st[0];
        step();
        res_valid_i = '0;
    endtask

    task automatic retire(input logic [7:0] tag, input logic [63:0] data,
                          input logic [4:0] st, input string name);
        `CHK({name, "_out_valid"}, out_valid_o, 1'b1)
        `CHK({name, "_tag"}, tag_o, tag)
        `CHK({name, "_result"}, result_o, data)
        `CHK({name, "_status"}, status_o, st)
        `CHK({name, "_ext"}, extension_bit_o, st[0])
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         n_iss;
        int         n_ret;
        int         cyc;
        logic [3:0] g_id  [20];
        int         g_due [20];
        bit         g_wb  [20];

        rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b1; in_chan_i = 2'd0; in_tag_i = '0;
        chan_ready_i = '1; res_valid_i = '0; res_id_i = '0; res_data_i = '0;
        res_status_i = '0; res_ext_i = '0; out_ready_i = 1'b0; clear_fflags_i = 1'b0;

        step();
        step();
        `CHK("rst_chan_valid", chan_valid_o, 4'b0000)
        rst_i = 1'b0; in_valid_i = 1'b0;
        step();
        `CHK("rst_out_valid", out_valid_o, 1'b0)
        `CHK("rst_busy", busy_o, 1'b0)
        `CHK("rst_fflags", fflags_o, 5'b00000)
        `CHK("rst_wb_err", wb_err_o, 1'b0)
        `CHK("rst_in_ready", in_ready_o, 1'b1)

        issue(2'd0, 8'd1, 4'd0, "a_iss1");
        issue(2'd1, 8'd2, 4'd1, "a_iss2");
        issue(2'd2, 8'd3, 4'd2, "a_iss3");
        `CHK("a_busy", busy_o, 1'b1)
        wb(2, 4'd2, 64'h33, 5'b00001);
        `CHK("a_head_pending", out_valid_o, 1'b0)
        `CHK("a_no_err", wb_err_o, 1'b0)
        wb(0, 4'd0, 64'h11, 5'b10000);
        `CHK("a_latency", out_valid_o, 1'b1)
        step();
        `CHK("a_hold_tag", tag_o, 8'd1)
        `CHK("a_hold_result", result_o, 64'h11)
        wb(1, 4'd1, 64'h22, 5'b00100);
        retire(8'd1, 64'h11, 5'b10000, "a_ret1");
        retire(8'd2, 64'h22, 5'b00100, "a_ret2");
        retire(8'd3, 64'h33, 5'b00001, "a_ret3");
        `CHK("a_fflags", fflags_o, 5'b10101)
        `CHK("a_idle", busy_o, 1'b0)
        `CHK("a_empty", out_valid_o, 1'b0)

        clear_fflags_i = 1'b1;
        step();
        clear_fflags_i = 1'b0;
        `CHK("clear_fflags", fflags_o, 5'b00000)

        for (int k = 0; k < 8; k++) begin
            issue(2'd0, 8'(8'h10 + k), 4'((3 + k) % 8), "c_fill");
        end
        in_valid_i = 1'b1; in_chan_i = 2'd1; in_tag_i = 8'h18;
        #1;
        `CHK("c_full_ready", in_ready_o, 1'b0)
        `CHK("c_full_chan_valid", chan_valid_o, 4'b0000)
        wb(0, 4'd3, 64'h1000, 5'b00010);
        out_ready_i = 1'b1;
        #1;
        `CHK("c_swap_ready", in_ready_o, 1'b1)
        `CHK("c_swap_chan_valid", chan_valid_o, 4'b0010)
        `CHK("c_swap_id", chan_id_o, 4'd3)
        `CHK("c_swap_tag", tag_o, 8'h10)
        step();
        in_valid_i = 1'b0; out_ready_i = 1'b0;
        step();
        in_valid_i = 1'b1;
        #1;
        `CHK("c_still_full", in_ready_o, 1'b0)
        in_valid_i = 1'b0;
        `CHK("c_fflags", fflags_o, 5'b00010)
        step();

        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        `CHK("d_busy", busy_o, 1'b0)
        `CHK("d_out_valid", out_valid_o, 1'b0)
        `CHK("d_fflags_kept", fflags_o, 5'b00010)
        wb(0, 4'd4, 64'hDEAD, 5'b11111);
        `CHK("d_late_no_err", wb_err_o, 1'b0)
        wb(1, 4'd3, 64'hBEEF, 5'b11111);
        `CHK("d_late_no_err2", wb_err_o, 1'b0)
        `CHK("d_late_out_valid", out_valid_o, 1'b0)

        issue(2'd3, 8'h40, 4'd8, "e_iss");
        wb(3, 4'd8, 64'hAA, 5'b00000);
        `CHK("e_first_no_err", wb_err_o, 1'b0)
        wb(3, 4'd8, 64'hBB, 5'b00000);
        `CHK("e_err_pulse", wb_err_o, 1'b1)
        step();
        `CHK("e_err_cleared", wb_err_o, 1'b0)
        retire(8'h40, 64'hAA, 5'b00000, "e_ret");

        issue(2'd0, 8'h50, 4'd9, "f_iss0");
        issue(2'd1, 8'h51, 4'd10, "f_iss1");
        res_status_i = '0; res_ext_i = '0;
        res_valid_i = 4'b0011;
        res_id_i[0 +: IDW] = 4'd9;   res_data_i[0 +: W] = 64'h500;
        res_id_i[IDW +: IDW] = 4'd10; res_data_i[W +: W] = 64'h510;
        out_ready_i = 1'b1;
        step();
        res_valid_i = '0;
        `CHK("f_n1_valid", out_valid_o, 1'b1)
        `CHK("f_n1_tag", tag_o, 8'h50)
        `CHK("f_n1_result", result_o, 64'h500)
        step();
        `CHK("f_n2_valid", out_valid_o, 1'b1)
        `CHK("f_n2_tag", tag_o, 8'h51)
        `CHK("f_n2_result", result_o, 64'h510)
        step();
        `CHK("f_drained", out_valid_o, 1'b0)
        out_ready_i = 1'b0;

        issue(2'd2, 8'h60, 4'd11, "f_iss2");
        res_valid_i = 4'b0110;
        res_id_i[IDW +: IDW] = 4'd11;   res_data_i[W +: W] = 64'h61;
        res_id_i[2*IDW +: IDW] = 4'd11; res_data_i[2*W +: W] = 64'h62;
        step();
        res_valid_i = '0;
        `CHK("f_same_err", wb_err_o, 1'b1)
        retire(8'h60, 64'h61, 5'b00000, "f_same_ret");

        n_iss = 0; n_ret = 0; cyc = 0;
        for (int k = 0; k < 20; k++) g_wb[k] = 1'b0;
        out_ready_i = 1'b1; res_status_i = '0; res_ext_i = '0;
        while (n_ret < 20 && cyc < 600) begin
            if (out_valid_o) begin
                `CHK("g_tag", tag_o, 8'(8'h80 + n_ret))
                `CHK("g_result", result_o, 64'hD000_0000_0000_0000 + 64'(n_ret))
                n_ret++;
            end
            res_valid_i = '0;
            for (int c = 0; c < NCH; c++) begin
                for (int k = 0; k < n_iss; k++) begin
                    if (!res_valid_i[c] && (k % NCH) == c && !g_wb[k] && g_due[k] <= cyc) begin
                        res_valid_i[c]         = 1'b1;
                        res_id_i[c*IDW +: IDW] = g_id[k];
                        res_data_i[c*W +: W]   = 64'hD000_0000_0000_0000 + 64'(k);
                        g_wb[k]                = 1'b1;
                    end
                end
            end
            in_valid_i = 1'b0;
            if (n_iss < 20) begin
                in_valid_i = 1'b1;
                in_chan_i  = 2'(n_iss % NCH);
                in_tag_i   = 8'(8'h80 + n_iss);
                #1;
                if (in_ready_o) begin
                    g_id[n_iss]  = chan_id_o;
                    g_due[n_iss] = cyc + 1 + int'($urandom_range(0, 9));
                    n_iss++;
                end
            end
            step();
            cyc++;
        end
        in_valid_i = 1'b0; res_valid_i = '0; out_ready_i = 1'b0;
        `CHK("g_all_retired", n_ret, 20)
        `CHK("g_idle", busy_o, 1'b0)

        issue(2'd0, 8'h99, 4'd8, "h_iss");
        wb(0, 4'd8, 64'h99, 5'b00001);
        `CHK("h_pre_valid", out_valid_o, 1'b1)
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        `CHK("h_out_valid", out_valid_o, 1'b0)
        `CHK("h_busy", busy_o, 1'b0)
        `CHK("h_fflags", fflags_o, 5'b00000)
        `CHK("h_chan_id", chan_id_o, 4'd0)

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`undef CHK
`default_nettype wire
